// File: rtl/sa_result_writeback.sv
// Output-side drain controller for the NxN systolic array: snapshots one PE row at a time,
// writes it to result memory in row-major order, then pulses an accumulator clear.
module sa_result_writeback #(
  parameter int N      = 8,
  parameter int ACC_W  = 20,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     addr_res,
  output logic [$clog2(N)-1:0]  row_sel,
  input  logic [N*ACC_W-1:0]    res_row,
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [ACC_W-1:0]      mem_wdata,
  input  logic                  mem_ready,
  output logic                  acc_clr,
  output logic                  busy,
  output logic                  done
);

  localparam int RW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_WRITE,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [RW-1:0]     row, col;
  logic [ADDR_W-1:0] base_q;
  logic [N*ACC_W-1:0] row_buf;

  logic xfer, last_col, last_row;

  assign xfer     = (state == S_WRITE) && mem_ready;
  assign last_col = (col == RW'(N - 1));
  assign last_row = (row == RW'(N - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_WRITE;
      S_WRITE: begin
        if (xfer && last_col) state_nxt = last_row ? S_CLEAR : S_LATCH;
      end
      S_CLEAR: state_nxt = S_DONE;
      S_DONE:  if (!start) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the row snapshot buffer is a plain register bank, so it is cleared with the rest of the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      row     <= '0;
      col     <= '0;
      base_q  <= '0;
      row_buf <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q <= addr_res;
            row    <= '0;
            col    <= '0;
          end
        end
        S_LATCH: begin
          row_buf <= res_row;
          col     <= '0;
        end
        S_WRITE: begin
          // A stall leaves row/col untouched, which freezes address and data.
          if (xfer) begin
            if (!last_col)     col <= col + 1'b1;
            else if (!last_row) row <= row + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode only registered state/counters; mem_ready never reaches mem_wen.
  always_comb begin
    row_sel   = row;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    acc_clr   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_LATCH: busy = 1'b1;
      S_WRITE: begin
        busy      = 1'b1;
        mem_wen   = 1'b1;
        // N is a power of two, so row*N + col is just the concatenation {row, col}.
        mem_addr  = base_q + ADDR_W'({row, col});
        mem_wdata = row_buf[col*ACC_W +: ACC_W];
      end
      S_CLEAR: begin
        busy    = 1'b1;
        acc_clr = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/sa_result_writeback.md
Name: sa_result_writeback

Overview:
- Output-side controller for the 8x8 systolic-array matrix multiplier (SAMM).
- Starts after the input-load controller finishes streaming operands and the PE accumulators hold the final C matrix.
- Selects one PE row at a time, snapshots that row, and writes its N accumulator values to result memory in row-major order with a ready/valid-style write handshake.
- After the last word it pulses an accumulator clear and reports done.

Parameters:
- N, 8, array dimension (rows = columns = N); power of two.
- ACC_W, 20, accumulator/result word width in bits.
- ADDR_W, 10, memory address width.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  level request; sampled only in IDLE.
- addr_res  input  ADDR_W  result-matrix base address; captured when start is accepted.
- row_sel  output  $clog2(N)  PE row driven onto res_row.
- res_row  input  N*ACC_W  accumulators of the selected row; column c at bits [c*ACC_W +: ACC_W]; valid combinationally from row_sel.
- mem_wen  output  1  write request (valid).
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  ACC_W  write data.
- mem_ready  input  1  memory accepts the word this cycle when mem_wen=1.
- acc_clr  output  1  one-cycle pulse clearing all PE accumulators.
- busy  output  1  high in LATCH, WRITE and CLEAR.
- done  output  1  high in DONE.

Behaviour:
- Reset: state=IDLE.
  - row, col, row_sel, mem_wen, mem_addr, mem_wdata, acc_clr, busy and done are all 0.
  - base_q and row_buf are cleared.
  - rst has priority over every other input in every state, including mid-write: the machine returns to IDLE and drops mem_wen the next cycle.
- State encoding is free. All outputs are decoded from registered state and counters, with no combinational path from mem_ready to mem_wen.
- IDLE: if start=1, capture base_q<=addr_res, row<=0, col<=0, then go to LATCH. Otherwise stay.
- LATCH (1 cycle):
  - row_sel=row.
  - row_buf<=res_row at the end of the cycle.
  - col<=0, then go to WRITE.
- WRITE:
  - mem_wen=1.
  - mem_addr=(base_q + row*N + col) mod 2^ADDR_W; wrap-around is silent.
  - mem_wdata=row_buf[col].
  - Transfer occurs when mem_wen & mem_ready.
  - No transfer: hold addr, data and counters unchanged for any number of stall cycles.
  - Transfer with col<N-1: col<=col+1.
  - Transfer with col==N-1 and row<N-1: row<=row+1, then go to LATCH.
  - Transfer with col==N-1 and row==N-1: go to CLEAR.
- CLEAR: acc_clr=1 for exactly one cycle, then go to DONE.
- DONE: done=1. Stay while start=1. When start=0, go to IDLE; done falls the cycle after.
  - Holding start high therefore never retriggers a second drain.
- start is ignored outside IDLE. Dropping start mid-drain does not pause or abort the drain.
- row_sel holds the current row value in all states; it is 0 in IDLE after reset.
- mem_wdata=0 and mem_addr=0 whenever mem_wen=0.
- Latency with mem_ready tied high:
  - start sampled at edge k gives LATCH in cycle k+1.
  - Each row takes 1 LATCH cycle plus N WRITE cycles.
  - For N=8, the last write is in cycle k+72, CLEAR in k+73, and done=1 from cycle k+74.
  - The total is exactly N*N writes, with no duplicates and no skipped words.

Test Plan:
- Basic drain: N=8, res_row driven so row r, column c = r*100+c, addr_res=0x040, start pulsed, mem_ready=1 -> 64 writes, addr 0x040..0x07F, data at addr 0x040+8r+c = r*100+c; acc_clr one pulse in cycle k+73; done=1 from cycle k+74.
- Backpressure: same stimulus with mem_ready toggled pseudo-randomly (~50%) -> identical 64 (addr,data) pairs in order; addr and data stable during every stall; done delayed by exactly the number of stall cycles.
- Address wrap: addr_res=0x3FA -> first write at 0x3FA, sixth word at 0x3FF, seventh word at 0x000, last at 0x039.
- Snapshot: change res_row for row 2 while row 2 is in WRITE -> written values are those present during row 2's LATCH cycle.
- Reset mid-operation: assert rst during row 3, col 5 of WRITE -> next cycle mem_wen=0, busy=0, row_sel=0; a following start restarts from row 0, col 0 with the new addr_res.
- Start handling: hold start high through the whole drain -> exactly one drain and done stays 1 while start=1; drop start -> IDLE next cycle; re-assert start -> second full drain of 64 writes.
